irq_request_unit: RTL and testbench
===================================

// Module: irq_request_unit
// PURPOSE
//  Peripheral-side counterpart of the core's interrupt controller. Collects N interrupt lines,
//  latches them as pending, arbitrates by fixed priority (lowest index wins), drives one request
//  (irq_req_o) to the core and releases it on the core's return pulse (irq_ret_i). Exposes the
//  serviced source id for the trap handler. Sits between peripherals and the core interrupt input.
// PARAMETERS
//  N_SRC      8         number of interrupt sources (2..32)
//  EDGE_MASK  8'hFF     per-source type: 1 = rising-edge triggered, 0 = level triggered
// PORTS
//  clk_i        in   1              core clock
//  rst_ni       in   1              reset, asynchronous, active-low
//  irq_line_i   in   N_SRC          peripheral interrupt lines, synchronous to clk_i
//  irq_en_i     in   N_SRC          per-source enable mask
//  irq_ret_i    in   1              single-cycle return pulse from core (mret of an interrupt)
//  irq_req_o    out  1              interrupt request to core
//  irq_id_o     out  $clog2(N_SRC)  index of source being serviced; valid while busy_o
//  pending_o    out  N_SRC          current pending vector (read-only status)
//  busy_o       out  1              a request is outstanding (state != IDLE)
// BEHAVIOUR
//  Reset (async, rst_ni=0): pending=0, line_q=0, state=IDLE, irq_req_o=0, irq_id_o=0,
//   busy_o=0. Reset mid-request drops the request immediately; no retained state.
//  Pending set, per source i, at each clk_i edge:
//   edge (EDGE_MASK[i]=1): set when irq_line_i[i] & ~line_q[i]; held until cleared by service.
//   level (EDGE_MASK[i]=0): pending[i] = irq_line_i[i] (no latching).
//  Clear: at the edge where irq_ret_i=1 in state REQ, pending[irq_id_o] clears (edge sources only).
//   Same-cycle new edge on that same source: set wins, pending stays 1.
//  Candidates = pending & irq_en_i; winner = lowest set index. Enable masks only arbitration,
//   never pending capture.
//  FSM (registered outputs):
//   IDLE: if candidates!=0 -> REQ, latch irq_id_o=winner, irq_req_o<=1. irq_ret_i ignored.
//   REQ:  irq_req_o held 1, irq_id_o frozen even if higher priority arrives or enable drops.
//         On irq_ret_i -> COOL, irq_req_o<=0, clear pending[irq_id_o].
//   COOL: one cycle, irq_req_o=0; -> IDLE unconditionally (gives core's irq_h time to clear).
//  Latency: edge-source line sampled high at edge t -> pending_o=1 after t -> irq_req_o=1 after t+1.
//   Back-to-back: after return, next request is raised no earlier than 3 edges after irq_ret_i.
//  Level source still asserted after return: re-requests via normal IDLE path (no suppression).
//  irq_ret_i asserted for >1 cycle: only the first cycle in REQ acts; later cycles land in
//   COOL/IDLE and are ignored.
//  busy_o = (state != IDLE). Widths: id is $clog2(N_SRC) bits, no arithmetic wrap concerns.
// STRUCTURE
//  Package irq_pkg: typedef enum logic [1:0] {IRQ_IDLE, IRQ_REQ, IRQ_COOL} irq_state_t;
//   localparam IRQ_CAUSE = 32'h80000010 (shared with the core's interrupt controller).
//  Sub-module irq_prio_encoder #(N): combinational; in vec, out idx + valid (lowest index first).
//  Top holds line_q, pending, FSM and output registers.
// TESTING
//  1 Reset: hold rst_ni=0 with lines=8'hFF -> irq_req_o=0, pending_o=0, busy_o=0; release -> normal.
//  2 Single edge: en=8'hFF, pulse line[3] one cycle -> pending_o=8'h08 next edge, irq_req_o=1
//    edge after, irq_id_o=3; irq_ret_i pulse -> irq_req_o=0, pending_o=0, IDLE after COOL.
//  3 Priority: lines 5 and 2 rise same cycle -> id=2 served first; after ret+COOL, id=5 requested.
//  4 Freeze: during REQ on id=4, raise line[0] and drop en[4] -> irq_id_o stays 4, irq_req_o stays 1.
//  5 Set wins: edge on line[1] in same cycle as irq_ret_i serving id=1 -> pending_o[1]=1, re-requests.
//  6 Async reset mid-REQ: assert rst_ni=0 between edges -> irq_req_o=0 before next clk_i edge.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and constants for the peripheral-side interrupt request unit.
package irq_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_REQ  = 2'd1,
    IRQ_COOL = 2'd2
  } irq_state_t;

  // mcause value the core's interrupt controller reports for this request path
  localparam logic [31:0] IRQ_CAUSE = 32'h8000_0010;

endpackage : irq_pkg

// File: rtl/irq_prio_encoder.sv
// Fixed-priority encoder: reports the lowest set bit of vec_i.
module irq_prio_encoder #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  vec_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  // Scan from the top down so the lowest set index is the last one written
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = IW'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule : irq_prio_encoder

// File: rtl/irq_request_unit.sv
// Interrupt request unit: captures peripheral lines as pending, picks the
// lowest-index enabled source, and holds one request to the core until the
// core's return pulse.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IRQ_IDLE | no request outstanding; raise one when a candidate exists
//   IRQ_REQ  | request held, id frozen; wait for irq_ret_i
//   IRQ_COOL | one dead cycle so the core's pending flag can drop
module irq_request_unit
  import irq_pkg::*;
#(
  parameter int                 N_SRC     = 8,
  parameter logic [N_SRC-1:0]   EDGE_MASK = '1,
  localparam int                IW        = $clog2(N_SRC)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_SRC-1:0] irq_line_i,
  input  logic [N_SRC-1:0] irq_en_i,
  input  logic             irq_ret_i,
  output logic             irq_req_o,
  output logic [IW-1:0]    irq_id_o,
  output logic [N_SRC-1:0] pending_o,
  output logic             busy_o
);

  irq_state_t       state_q, state_d;
  logic [N_SRC-1:0] line_q;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic             req_q, req_d;
  logic [IW-1:0]    id_q, id_d;

  logic [N_SRC-1:0] candidates;
  logic [IW-1:0]    winner;
  logic             winner_valid;
  logic             clr_en;

  // Enable only gates arbitration; capture into pending is unconditional
  assign candidates = pending_q & irq_en_i;

  irq_prio_encoder #(
    .N  (N_SRC),
    .IW (IW)
  ) u_prio (
    .vec_i   (candidates),
    .idx_o   (winner),
    .valid_o (winner_valid)
  );

  // Pending next state: edge sources latch until serviced (a fresh edge beats
  // the clear), level sources simply follow the line
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < N_SRC; i++) begin
      if (EDGE_MASK[i]) begin
        pending_d[i] = (pending_q[i] & ~(clr_en && (id_q == IW'(i))))
                     | (irq_line_i[i] & ~line_q[i]);
      end else begin
        pending_d[i] = irq_line_i[i];
      end
    end
  end

  // Request FSM next state and registered-output next values
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    id_d    = id_q;
    clr_en  = 1'b0;
    unique case (state_q)
      IRQ_IDLE: begin
        if (winner_valid) begin
          state_d = IRQ_REQ;
          req_d   = 1'b1;
          id_d    = winner;
        end
      end
      IRQ_REQ: begin
        req_d = 1'b1;
        if (irq_ret_i) begin
          state_d = IRQ_COOL;
          req_d   = 1'b0;
          clr_en  = 1'b1;
        end
      end
      IRQ_COOL: begin
        state_d = IRQ_IDLE;
        req_d   = 1'b0;
      end
      default: begin
        state_d = IRQ_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State, line history, pending and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IRQ_IDLE;
      line_q    <= '0;
      pending_q <= '0;
      req_q     <= 1'b0;
      id_q      <= '0;
    end else begin
      state_q   <= state_d;
      line_q    <= irq_line_i;
      pending_q <= pending_d;
      req_q     <= req_d;
      id_q      <= id_d;
    end
  end

  assign irq_req_o = req_q;
  assign irq_id_o  = id_q;
  assign pending_o = pending_q;
  assign busy_o    = (state_q != IRQ_IDLE);

endmodule : irq_request_unit

// File: tb/tb_irq_request_unit.sv
// Directed bench for irq_request_unit; source 7 is configured level-triggered.
module tb_irq_request_unit;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [7:0] irq_line_i;
  logic [7:0] irq_en_i;
  logic       irq_ret_i;
  logic       irq_req_o;
  logic [2:0] irq_id_o;
  logic [7:0] pending_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;

  irq_request_unit #(
    .N_SRC     (8),
    .EDGE_MASK (8'h7F)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .irq_line_i (irq_line_i),
    .irq_en_i   (irq_en_i),
    .irq_ret_i  (irq_ret_i),
    .irq_req_o  (irq_req_o),
    .irq_id_o   (irq_id_o),
    .pending_o  (pending_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] line;
    logic [7:0] en;
    logic       ret;
    logic       req;
    logic [2:0] id;
    logic [7:0] pend;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [7:0] line, logic [7:0] en, logic ret,
                              logic req, logic [2:0] id, logic [7:0] pend, logic busy);
    vec_t v;
    v.line = line; v.en = en; v.ret = ret;
    v.req = req; v.id = id; v.pend = pend; v.busy = busy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // Expected values are the state after the edge that samples the inputs.
    //               line   en     ret   req   id    pend   busy
    // single edge on source 3
    vecs.push_back(mk(8'h08, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h08, 1'b0));
    vecs.push_back(mk(8'h00, 8'hFF, 1'b0, 1'b1, 3'd3, 8'h08, 1'b1));
    vecs.push_back(mk(8'h00, 8'hFF, 1'b0, 1'b1, 3'd3, 8'h08, 1'b1));
    vecs.push_back(mk(8'h00, 8'hFF, 1'b1, 1'b0, 3'd3, 8'h00, 1'b1));
    vecs.push_back(mk(8'h00, 8'hFF, 1'b0, 1'b0, 3'd3, 8'h00, 1'b0));
    // priority: 5 and 2 together
    vecs.push_back(mk(8'h24, 8'hFF, 1'b0, 1'b0, 3'd3, 8'h24, 1'b0));
    vecs.push_back(mk(8'h00, 8'hFF, 1'b0, 1'b1, 3'd2, 8'h24, 1'b1));
    vecs.push_back(mk(8'h00, 8'hFF, 1'b1, 1'b0, 3'd2, 8'h20, 1'b1));
    vecs.push_back(mk(8'h00, 8'hFF, 1'b0, 1'b0, 3'd2, 8'h20, 1'b0));
    vecs.push_back(mk(8'h00, 8'hFF, 1'b0, 1'b1, 3'd5, 8'h20, 1'b1));
    vecs.push_back(mk(8'h00, 8'hFF, 1'b1, 1'b0, 3'd5, 8'h00, 1'b1));
    vecs.push_back(mk(8'h00, 8'hFF, 1'b0, 1'b0, 3'd5, 8'h00, 1'b0));
    // freeze: id 4 held while line 0 rises and en[4] drops
    vecs.push_back(mk(8'h10, 8'hFF, 1'b0, 1'b0, 3'd5, 8'h10, 1'b0));
    vecs.push_back(mk(8'h00, 8'hFF, 1'b0, 1'b1, 3'd4, 8'h10, 1'b1));
    vecs.push_back(mk(8'h01, 8'hEF, 1'b0, 1'b1, 3'd4, 8'h11, 1'b1));
    vecs.push_back(mk(8'h00, 8'hEF, 1'b0, 1'b1, 3'd4, 8'h11, 1'b1));
    vecs.push_back(mk(8'h00, 8'hEF, 1'b1, 1'b0, 3'd4, 8'h01, 1'b1));
    vecs.push_back(mk(8'h00, 8'hEF, 1'b0, 1'b0, 3'd4, 8'h01, 1'b0));
    vecs.push_back(mk(8'h00, 8'hEF, 1'b0, 1'b1, 3'd0, 8'h01, 1'b1));
    vecs.push_back(mk(8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1));
    vecs.push_back(mk(8'h00, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0));
    // set wins over clear on source 1
    vecs.push_back(mk(8'h02, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h02, 1'b0));
    vecs.push_back(mk(8'h00, 8'hFF, 1'b0, 1'b1, 3'd1, 8'h02, 1'b1));
    vecs.push_back(mk(8'h02, 8'hFF, 1'b1, 1'b0, 3'd1, 8'h02, 1'b1));
    vecs.push_back(mk(8'h00, 8'hFF, 1'b0, 1'b0, 3'd1, 8'h02, 1'b0));
    vecs.push_back(mk(8'h00, 8'hFF, 1'b0, 1'b1, 3'd1, 8'h02, 1'b1));
    vecs.push_back(mk(8'h00, 8'hFF, 1'b1, 1'b0, 3'd1, 8'h00, 1'b1));
    vecs.push_back(mk(8'h00, 8'hFF, 1'b0, 1'b0, 3'd1, 8'h00, 1'b0));
    // level source 7: follows the line, re-requests while held
    vecs.push_back(mk(8'h80, 8'hFF, 1'b0, 1'b0, 3'd1, 8'h80, 1'b0));
    vecs.push_back(mk(8'h80, 8'hFF, 1'b0, 1'b1, 3'd7, 8'h80, 1'b1));
    vecs.push_back(mk(8'h80, 8'hFF, 1'b1, 1'b0, 3'd7, 8'h80, 1'b1));
    vecs.push_back(mk(8'h80, 8'hFF, 1'b0, 1'b0, 3'd7, 8'h80, 1'b0));
    vecs.push_back(mk(8'h80, 8'hFF, 1'b0, 1'b1, 3'd7, 8'h80, 1'b1));
    vecs.push_back(mk(8'h00, 8'hFF, 1'b1, 1'b0, 3'd7, 8'h00, 1'b1));
    vecs.push_back(mk(8'h00, 8'hFF, 1'b0, 1'b0, 3'd7, 8'h00, 1'b0));
    // enable masks arbitration only
    vecs.push_back(mk(8'h08, 8'h00, 1'b0, 1'b0, 3'd7, 8'h08, 1'b0));
    vecs.push_back(mk(8'h00, 8'h00, 1'b0, 1'b0, 3'd7, 8'h08, 1'b0));
    vecs.push_back(mk(8'h00, 8'h08, 1'b0, 1'b1, 3'd3, 8'h08, 1'b1));
    vecs.push_back(mk(8'h00, 8'h08, 1'b1, 1'b0, 3'd3, 8'h00, 1'b1));
    vecs.push_back(mk(8'h00, 8'hFF, 1'b0, 1'b0, 3'd3, 8'h00, 1'b0));
    // return pulse in IDLE is ignored; held return acts once
    vecs.push_back(mk(8'h00, 8'hFF, 1'b1, 1'b0, 3'd3, 8'h00, 1'b0));
    vecs.push_back(mk(8'h04, 8'hFF, 1'b0, 1'b0, 3'd3, 8'h04, 1'b0));
    vecs.push_back(mk(8'h00, 8'hFF, 1'b0, 1'b1, 3'd2, 8'h04, 1'b1));
    vecs.push_back(mk(8'h00, 8'hFF, 1'b1, 1'b0, 3'd2, 8'h00, 1'b1));
    vecs.push_back(mk(8'h00, 8'hFF, 1'b1, 1'b0, 3'd2, 8'h00, 1'b0));
    vecs.push_back(mk(8'h00, 8'hFF, 1'b1, 1'b0, 3'd2, 8'h00, 1'b0));

    // Reset held with all lines high
    rst_ni     = 1'b0;
    irq_line_i = 8'hFF;
    irq_en_i   = 8'hFF;
    irq_ret_i  = 1'b0;
    tick();
    tick();
    chk("rst_req",  irq_req_o, 1'b0);
    chk("rst_pend", pending_o, 8'h00);
    chk("rst_busy", busy_o,    1'b0);
    chk("rst_id",   irq_id_o,  3'd0);
    irq_line_i = 8'h00;
    rst_ni     = 1'b1;
    tick();
    chk("post_rst_pend", pending_o, 8'h00);
    chk("post_rst_busy", busy_o,    1'b0);

    foreach (vecs[k]) begin
      irq_line_i = vecs[k].line;
      irq_en_i   = vecs[k].en;
      irq_ret_i  = vecs[k].ret;
      tick();
      chk($sformatf("v%0d_req", k),  irq_req_o, vecs[k].req);
      chk($sformatf("v%0d_id", k),   irq_id_o,  vecs[k].id);
      chk($sformatf("v%0d_pend", k), pending_o, vecs[k].pend);
      chk($sformatf("v%0d_busy", k), busy_o,    vecs[k].busy);
    end

    // Async reset in the middle of a request drops it before the next edge
    irq_ret_i  = 1'b0;
    irq_line_i = 8'h20;
    tick();
    irq_line_i = 8'h00;
    tick();
    chk("mid_req_up", irq_req_o, 1'b1);
    chk("mid_req_id", irq_id_o,  3'd5);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("arst_req",  irq_req_o, 1'b0);
    chk("arst_busy", busy_o,    1'b0);
    chk("arst_pend", pending_o, 8'h00);
    chk("arst_id",   irq_id_o,  3'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    tick();
    chk("arst_after_req",  irq_req_o, 1'b0);
    chk("arst_after_pend", pending_o, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_irq_request_unit
